teclado_scan_matrix: RTL and testbench

Parametrised successor to the team's 4x4 keypad scanner. It drives a row-strobe matrix keypad and synchronises and debounces the column inputs. It reports each key press as a one-cycle key_valid pulse with a binary key code, plus a held flag and a multi-key error flag. It sits between the board keypad pins and the application logic (ColorMix control) and replaces the divider, row reader and shift-AND debounce chain with a single FSM-based block.

---
 rtl/teclado_pkg.sv | 23 ++
 rtl/teclado_tick_gen.sv | 24 ++
 rtl/teclado_scan_matrix.sv | 235 +++++++++++++++++++++++
 tb/tb_teclado_scan_matrix.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/teclado_pkg.sv
// Shared types and helpers for the parametrised row-strobe keypad scanner.
package teclado_pkg;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } state_t;

  localparam int MAX_ROWS = 32;

  // Width of a binary index into n items; never narrower than one bit.
  function automatic int code_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Row strobe after reset: row 0 driven low, every other row idle high.
  function automatic logic [MAX_ROWS-1:0] fila_reset();
    return {{(MAX_ROWS-1){1'b1}}, 1'b0};
  endfunction

endpackage

// File: rtl/teclado_tick_gen.sv
// Free-running scan tick: one-cycle pulse every SCAN_DIV clk50 cycles.
module teclado_tick_gen #(
  parameter int SCAN_DIV = 50000
) (
  input  logic clk50,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  assign tick = (r_cnt == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk50) begin
    if (rst)       r_cnt <= '0;
    else if (tick) r_cnt <= '0;
    else           r_cnt <= r_cnt + CNT_W'(1);
  end

endmodule

// File: rtl/teclado_scan_matrix.sv
// Row-strobe keypad scanner with column sync, debounce, held and multi-key flags.
// Define TECLADO_REPEAT_EN to add auto-repeat of key_valid while a key stays held.
module teclado_scan_matrix
  import teclado_pkg::*;
#(
  parameter  int ROWS        = 4,
  parameter  int COLS        = 4,
  parameter  int SCAN_DIV    = 50000,
  parameter  int DEBOUNCE    = 4,
  parameter  int REPEAT_DLY  = 500,
  parameter  int REPEAT_RATE = 100,
  localparam int CODE_W      = code_width(ROWS * COLS)
) (
  input  logic              clk50,
  input  logic              rst,
  input  logic [COLS-1:0]   Columna,
  output logic [ROWS-1:0]   Fila,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_held,
  output logic              multi_err
);

  localparam int ROW_W = code_width(ROWS);
  localparam int COL_W = code_width(COLS);
  localparam int DB_W  = $clog2(DEBOUNCE + 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [ROWS-1:0]  FILA_RST = ROWS'(fila_reset());

  logic              w_tick;
  logic [COLS-1:0]   r_col_s1, r_col_s2;
  logic [COLS-1:0]   w_low;
  logic              w_none, w_single, w_multi;
  logic [COL_W-1:0]  w_col_idx;
  logic [CODE_W-1:0] w_code;
  logic [ROW_W-1:0]  w_row_adv;

  state_t            r_state, w_state_nxt;
  logic [ROW_W-1:0]  r_row, w_row_nxt;
  logic [ROWS-1:0]   r_fila, w_fila_nxt;
  logic [DB_W-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [COL_W-1:0]  r_col, w_col_nxt;
  logic [CODE_W-1:0] r_key_code, w_code_nxt;
  logic              r_key_valid, w_valid_nxt;
  logic              r_key_held, w_held_nxt;
  logic              r_multi_err, w_multi_nxt;
  logic              w_accept, w_advance;

`ifdef TECLADO_REPEAT_EN
  localparam int HOLD_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
  localparam logic [HOLD_W-1:0] HOLD_DLY  = HOLD_W'(REPEAT_DLY);
  localparam logic [HOLD_W-1:0] HOLD_RATE = HOLD_W'(REPEAT_RATE);

  logic [HOLD_W-1:0] r_hold, w_hold_nxt, w_hold_inc;
  logic              r_rep_phase, w_rep_phase_nxt;
`endif

  teclado_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk50 (clk50),
    .rst   (rst),
    .tick  (w_tick)
  );

  // Columns idle high, so the synchroniser resets to "no key" rather than to a phantom press.
  always_ff @(posedge clk50) begin
    if (rst) begin
      r_col_s1 <= '1;
      r_col_s2 <= '1;
    end else begin
      r_col_s1 <= Columna;
      r_col_s2 <= r_col_s1;
    end
  end

  assign w_low     = ~r_col_s2;
  assign w_none    = ($countones(w_low) == 0);
  assign w_single  = ($countones(w_low) == 1);
  assign w_multi   = ($countones(w_low) > 1);
  assign w_cnt_inc = r_cnt + DB_W'(1);
  assign w_row_adv = (r_row == ROW_LAST) ? '0 : r_row + ROW_W'(1);
  assign w_code    = CODE_W'(int'(r_row) * COLS + int'(w_col_idx));

  always_comb begin
    w_col_idx = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (w_low[c]) w_col_idx = COL_W'(c);
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_cnt_nxt   = r_cnt;
    w_col_nxt   = r_col;
    w_code_nxt  = r_key_code;
    w_valid_nxt = 1'b0;
    w_held_nxt  = r_key_held;
    w_multi_nxt = 1'b0;
    w_accept    = 1'b0;
    w_advance   = 1'b0;
`ifdef TECLADO_REPEAT_EN
    w_hold_nxt      = r_hold;
    w_rep_phase_nxt = r_rep_phase;
    w_hold_inc      = r_hold + HOLD_W'(1);
`endif

    if (w_tick) begin
      unique case (r_state)
        ST_SCAN: begin
          if (w_single) begin
            w_col_nxt = w_col_idx;
            if (DEBOUNCE == 1) begin
              w_accept = 1'b1;
            end else begin
              w_state_nxt = ST_DEBOUNCE;
              w_cnt_nxt   = DB_W'(1);
            end
          end else begin
            w_multi_nxt = w_multi;
            w_advance   = 1'b1;
          end
        end
        ST_DEBOUNCE: begin
          if (w_single && (w_col_idx == r_col)) begin
            if (w_cnt_inc == DB_LAST) w_accept  = 1'b1;
            else                      w_cnt_nxt = w_cnt_inc;
          end else begin
            w_advance = 1'b1;
          end
        end
        ST_PRESSED: begin
          // Any non-idle pattern keeps the accepted key pressed; only all-high starts a release.
          if (w_none) begin
            if (DEBOUNCE == 1) begin
              w_advance = 1'b1;
            end else begin
              w_state_nxt = ST_RELEASE;
              w_cnt_nxt   = DB_W'(1);
            end
`ifdef TECLADO_REPEAT_EN
            w_hold_nxt      = '0;
            w_rep_phase_nxt = 1'b0;
          end else begin
            if (w_hold_inc == (r_rep_phase ? HOLD_RATE : HOLD_DLY)) begin
              w_valid_nxt     = 1'b1;
              w_hold_nxt      = '0;
              w_rep_phase_nxt = 1'b1;
            end else begin
              w_hold_nxt = w_hold_inc;
            end
`endif
          end
        end
        ST_RELEASE: begin
          if (w_none) begin
            if (w_cnt_inc == DB_LAST) w_advance = 1'b1;
            else                      w_cnt_nxt = w_cnt_inc;
          end else begin
            w_state_nxt = ST_PRESSED;
            w_cnt_nxt   = '0;
          end
        end
        default: w_advance = 1'b1;
      endcase
    end

    if (w_accept) begin
      w_state_nxt = ST_PRESSED;
      w_cnt_nxt   = '0;
      w_code_nxt  = w_code;
      w_valid_nxt = 1'b1;
      w_held_nxt  = 1'b1;
`ifdef TECLADO_REPEAT_EN
      w_hold_nxt      = '0;
      w_rep_phase_nxt = 1'b0;
`endif
    end

    if (w_advance) begin
      w_state_nxt = ST_SCAN;
      w_cnt_nxt   = '0;
      w_row_nxt   = w_row_adv;
      w_held_nxt  = 1'b0;
    end

    w_fila_nxt            = '1;
    w_fila_nxt[w_row_nxt] = 1'b0;
  end

  always_ff @(posedge clk50) begin
    if (rst) begin
      r_state     <= ST_SCAN;
      r_row       <= '0;
      r_fila      <= FILA_RST;
      r_cnt       <= '0;
      r_col       <= '0;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
      r_multi_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_row       <= w_row_nxt;
      r_fila      <= w_fila_nxt;
      r_cnt       <= w_cnt_nxt;
      r_col       <= w_col_nxt;
      r_key_code  <= w_code_nxt;
      r_key_valid <= w_valid_nxt;
      r_key_held  <= w_held_nxt;
      r_multi_err <= w_multi_nxt;
    end
  end

`ifdef TECLADO_REPEAT_EN
  always_ff @(posedge clk50) begin
    if (rst) begin
      r_hold      <= '0;
      r_rep_phase <= 1'b0;
    end else begin
      r_hold      <= w_hold_nxt;
      r_rep_phase <= w_rep_phase_nxt;
    end
  end
`endif

  assign Fila      = r_fila;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;
  assign multi_err = r_multi_err;

endmodule

// File: tb/tb_teclado_scan_matrix.sv
// Scoreboard bench: a physical keypad model drives Columna from Fila; a monitor checks every key_valid.
module tb_teclado_scan_matrix;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 4;
  localparam int REPEAT_DLY = 8;
  localparam int REPEAT_RATE = 3;
  localparam int CODE_W = 4;

  logic              clk50 = 1'b0;
  logic              rst;
  logic [COLS-1:0]   Columna;
  logic [ROWS-1:0]   Fila;
  logic [CODE_W-1:0] key_code;
  logic              key_valid;
  logic              key_held;
  logic              multi_err;

  logic pressed [ROWS][COLS];
  int   exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_multi  = 0;
  logic prev_multi = 1'b0;

  teclado_scan_matrix #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE),
    .REPEAT_DLY(REPEAT_DLY), .REPEAT_RATE(REPEAT_RATE)
  ) dut (
    .clk50     (clk50),
    .rst       (rst),
    .Columna   (Columna),
    .Fila      (Fila),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held),
    .multi_err (multi_err)
  );

  always #5 clk50 = ~clk50;

  // A pressed key shorts its column to its row line, so the column reads low only while that row is strobed.
  always_comb begin
    Columna = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (pressed[r][c] && !Fila[r]) Columna[c] = 1'b0;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic release_all();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        pressed[r][c] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk50);
    check("reset_fila", int'(Fila), 4'b1110);
    check("reset_code", int'(key_code), 0);
    check("reset_valid", int'(key_valid), 0);
    check("reset_held", int'(key_held), 0);
    check("reset_multi", int'(multi_err), 0);
    rst = 1'b0;
  endtask

  // kind 0: clean press, 1: bounce shorter than the debounce window, 2: two keys on one row.
  task automatic episode(input int kind, input int r, input int c, input int c2);
    int multi_start;
    logic [ROWS-1:0] f0;
    multi_start = n_multi;
    case (kind)
      0: begin
        exp_q.push_back(r * COLS + c);
        pressed[r][c] = 1'b1;
        repeat (40 + $urandom_range(0, 2)) @(negedge clk50);
        check("held_while_pressed", int'(key_held), 1);
      end
      1: begin
        pressed[r][c] = 1'b1;
        repeat ($urandom_range(1, 7)) @(negedge clk50);
      end
      default: begin
        pressed[r][c]  = 1'b1;
        pressed[r][c2] = 1'b1;
        repeat (40) @(negedge clk50);
      end
    endcase
    release_all();
    repeat (40) @(negedge clk50);
    check("valid_queue_drained", exp_q.size(), 0);
    check("held_after_release", int'(key_held), 0);
    if (kind == 2) check_range("multi_pulse_count", n_multi - multi_start, 2, 3);
    else           check("no_multi_pulse", n_multi - multi_start, 0);
    f0 = Fila;
    repeat (SCAN_DIV) @(negedge clk50);
    check("scan_resumed", int'(Fila == f0), 0);
  endtask

  // Monitor: every key_valid must match the oldest outstanding expected code.
  always @(negedge clk50) begin
    if (key_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", int'(key_valid), 0);
      end else begin
        check("key_code", int'(key_code), exp_q.pop_front());
        check("held_at_valid", int'(key_held), 1);
      end
    end
    if (multi_err) begin
      n_multi++;
      check("multi_err_one_cycle", int'(prev_multi), 0);
    end
    prev_multi = multi_err;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n_rep;
    logic [3:0] f_exp;
    release_all();
    rst = 1'b1;

    do_reset();
    for (int k = 0; k < 5; k++) begin
      repeat ((k == 0) ? 2 : SCAN_DIV) @(negedge clk50);
      f_exp = ~(4'b0001 << (k % ROWS));
      check("row_rotation", int'(Fila), int'(f_exp));
    end

    episode(0, 2, 1, 0);
    episode(1, 1, 2, 0);
    episode(2, 0, 0, 1);

    // Reset after two matching samples: the press must be re-detected from scratch.
    do_reset();
    pressed[0][2] = 1'b1;
    repeat (10) @(negedge clk50);
    rst = 1'b1;
    repeat (3) @(negedge clk50);
    check("midreset_held", int'(key_held), 0);
    rst = 1'b0;
    exp_q.push_back(2);
    lat = 0;
    while (!key_valid && lat < 40) begin
      @(negedge clk50);
      lat++;
    end
    check("midreset_latency", lat, 4 * SCAN_DIV);
    release_all();
    repeat (40) @(negedge clk50);
    check("midreset_drained", exp_q.size(), 0);

    // Long hold: one pulse, or acceptance plus five repeats when auto-repeat is built in.
`ifdef TECLADO_REPEAT_EN
    n_rep = 6;
`else
    n_rep = 1;
`endif
    for (int i = 0; i < n_rep; i++) exp_q.push_back(1 * COLS + 3);
    pressed[1][3] = 1'b1;
    lat = 0;
    while (!key_valid && lat < 100) begin
      @(negedge clk50);
      lat++;
    end
    check_range("long_hold_accepted", lat, 1, 99);
    repeat (20 * SCAN_DIV + 1) @(negedge clk50);
    check("long_hold_held", int'(key_held), 1);
    release_all();
    repeat (60) @(negedge clk50);
    check("long_hold_pulses", n_rep - exp_q.size(), n_rep);
    exp_q.delete();

    for (int i = 0; i < 40; i++) begin
      int r, c, c2;
      r  = $urandom_range(0, ROWS - 1);
      c  = $urandom_range(0, COLS - 1);
      c2 = (c + $urandom_range(1, COLS - 1)) % COLS;
      episode($urandom_range(0, 2), r, c, c2);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
